// File: rtl/sdram_write_burst.sv
// SDR SDRAM write engine: drains a first-word-fall-through FIFO into open-row
// write streams, with refresh priority, tWR recovery and row/bank crossing.
module sdram_write_burst #(
    parameter int DQ_WIDTH  = 16,
    parameter int BANK_BITS = 2,
    parameter int ROW_BITS  = 12,
    parameter int COL_BITS  = 8,
    parameter int BEATS     = 2,
    parameter int T_RCD     = 2,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2,
    parameter int T_RFC     = 8
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [BANK_BITS+ROW_BITS+COL_BITS-1:0]        address,
    input  logic                                          auto_refresh,
    output logic                                          ready,
    output logic                                          busy,
    output logic                                          refresh_ack,
    output logic [2:0]                                    command,
    output logic [ROW_BITS-1:0]                           addr,
    output logic [BANK_BITS-1:0]                          bank,
    output logic [DQ_WIDTH-1:0]                           dq_out,
    output logic [DQ_WIDTH/8-1:0]                         dq_mask,
    output logic                                          dq_oe,
    input  logic [BEATS*(DQ_WIDTH+DQ_WIDTH/8)-1:0]        fifo_data,
    input  logic                                          fifo_empty,
    output logic                                          fifo_rd
);

    localparam int ADDR_W = BANK_BITS + ROW_BITS + COL_BITS;
    localparam int MASK_W = DQ_WIDTH / 8;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int DLY_W  = $clog2(T_RFC + T_RCD + T_WR + T_RP + 1);
    localparam int WR_DRY = (T_WR > 1) ? T_WR - 2 : 0;

    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_AR    = 3'b001;

    localparam logic [ROW_BITS-1:0] A10_ALL = ROW_BITS'(1) << 10;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVATE,
        WRITE,
        WR_RECOVER,
        PRECHARGE,
        REFRESH
    } state_t;

    state_t                state, state_n;
    logic [DLY_W-1:0]      delay, delay_n;
    logic [BEAT_W-1:0]     beat, beat_n;
    logic [ADDR_W-1:0]     waddr, waddr_n;
    logic                  pending;
    logic                  ar_issue;

    logic [BANK_BITS-1:0]  cur_bank;
    logic [ROW_BITS-1:0]   cur_row;
    logic [COL_BITS-1:0]   cur_col;
    logic [ADDR_W-1:0]     waddr_inc;
    logic                  col_wrap;
    logic                  tick;
    logic                  refresh_now;
    logic                  start_ok;
    logic                  last_beat;

    logic [DQ_WIDTH-1:0]   beat_data [BEATS];
    logic [MASK_W-1:0]     beat_mask [BEATS];

    // Beat 0 sits in the most-significant slice of both the data and mask fields.
    for (genvar b = 0; b < BEATS; b++) begin : g_beat
        assign beat_data[b] = fifo_data[(BEATS-1-b)*DQ_WIDTH +: DQ_WIDTH];
        assign beat_mask[b] = fifo_data[BEATS*DQ_WIDTH + (BEATS-1-b)*MASK_W +: MASK_W];
    end

    assign cur_bank    = waddr[ADDR_W-1 -: BANK_BITS];
    assign cur_row     = waddr[COL_BITS +: ROW_BITS];
    assign cur_col     = waddr[COL_BITS-1:0];
    assign waddr_inc   = waddr + ADDR_W'(1);
    assign col_wrap    = (waddr_inc[COL_BITS-1:0] == '0);
    assign tick        = auto_refresh & en;
    assign refresh_now = pending | tick;
    assign start_ok    = en & ~fifo_empty;
    assign last_beat   = (beat == BEAT_W'(BEATS-1));

    assign ready = (state == IDLE) && (delay == '0) && !pending;
    assign busy  = (state != IDLE) || (delay != '0);

    always_comb begin
        state_n     = state;
        delay_n     = delay;
        beat_n      = beat;
        waddr_n     = waddr;
        ar_issue    = 1'b0;
        command     = CMD_NOP;
        addr        = '0;
        bank        = '0;
        dq_out      = '0;
        dq_mask     = '0;
        dq_oe       = 1'b0;
        fifo_rd     = 1'b0;
        refresh_ack = 1'b0;

        if (delay != '0) begin
            delay_n = delay - DLY_W'(1);
        end else begin
            unique case (state)
                IDLE: begin
                    if (refresh_now) begin
                        command     = CMD_AR;
                        ar_issue    = 1'b1;
                        refresh_ack = 1'b1;
                        delay_n     = DLY_W'(T_RFC - 1);
                    end else if (start_ok) begin
                        waddr_n = address;
                        state_n = ACTIVATE;
                    end
                end

                ACTIVATE: begin
                    command = CMD_ACT;
                    addr    = cur_row;
                    bank    = cur_bank;
                    delay_n = DLY_W'(T_RCD - 1);
                    beat_n  = '0;
                    state_n = WRITE;
                end

                WRITE: begin
                    if (beat == '0 && fifo_empty) begin
                        // Stream ran dry after the previous entry: this NOP already
                        // counts as the first write-recovery cycle.
                        if (T_WR > 1) begin
                            state_n = WR_RECOVER;
                            delay_n = DLY_W'(WR_DRY);
                        end else begin
                            state_n = PRECHARGE;
                        end
                    end else begin
                        command = CMD_WRITE;
                        addr    = ROW_BITS'(cur_col);
                        bank    = cur_bank;
                        dq_out  = beat_data[beat];
                        dq_mask = beat_mask[beat];
                        dq_oe   = 1'b1;
                        waddr_n = waddr_inc;
                        if (last_beat) begin
                            fifo_rd = ~fifo_empty;
                            beat_n  = '0;
                            if (!en || refresh_now || col_wrap) begin
                                state_n = WR_RECOVER;
                                delay_n = DLY_W'(T_WR - 1);
                            end
                        end else begin
                            beat_n = beat + BEAT_W'(1);
                        end
                    end
                end

                WR_RECOVER: begin
                    state_n = PRECHARGE;
                end

                PRECHARGE: begin
                    command = CMD_PRE;
                    addr    = A10_ALL;
                    bank    = cur_bank;
                    delay_n = DLY_W'(T_RP - 1);
                    if (refresh_now) begin
                        state_n = REFRESH;
                    end else if (start_ok) begin
                        state_n = ACTIVATE;
                    end else begin
                        state_n = IDLE;
                    end
                end

                REFRESH: begin
                    command     = CMD_AR;
                    ar_issue    = 1'b1;
                    refresh_ack = 1'b1;
                    delay_n     = DLY_W'(T_RFC - 1);
                    state_n     = start_ok ? ACTIVATE : IDLE;
                end

                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // A tick landing on the AR cycle is absorbed by that AR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            delay   <= '0;
            beat    <= '0;
            pending <= 1'b0;
        end else begin
            state <= state_n;
            delay <= delay_n;
            beat  <= beat_n;
            if (ar_issue) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        waddr <= waddr_n;
    end

endmodule

// File: doc/sdram_write_burst.md
Name: sdram_write_burst

Overview:
- Parametrised SDRAM write engine; drains a first-word-fall-through (FWFT) write FIFO into SDR SDRAM.
- Sits under the wb_sdram controller, alongside the read engine. The controller grants the bus with en and forwards refresh ticks.
- Generalises data width, geometry, beats per FIFO entry and timing. Adds open-row streaming, row/bank-crossing handling, refresh priority, tWR recovery and an explicit dq output enable.

Parameters:
- DQ_WIDTH, 16, SDRAM data bus width; multiple of 8.
- BANK_BITS, 2, bank address bits.
- ROW_BITS, 12, row address bits; must be >= 11.
- COL_BITS, 8, column address bits; must be <= 10.
- BEATS, 2, DQ words per FIFO entry.
- T_RCD, 2, ACT-to-WRITE delay in clocks.
- T_WR, 2, last WRITE to PRE delay in clocks.
- T_RP, 2, PRE to next command delay in clocks.
- T_RFC, 8, AR to next command delay in clocks.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  bus grant from controller.
- address  in  BANK_BITS+ROW_BITS+COL_BITS  start word address, laid out {bank,row,col}.
- auto_refresh  in  1  one-cycle refresh tick.
- ready  out  1  idle and able to accept a new start.
- busy  out  1  high whenever state != IDLE or the delay counter is non-zero.
- refresh_ack  out  1  one-cycle pulse on the cycle AR is issued.
- command  out  3  {ras_n,cas_n,we_n}. NOP=111, ACT=011, WRITE=100, PRE=010, AR=001.
- addr  out  ROW_BITS  SDRAM address bus.
- bank  out  BANK_BITS  SDRAM bank select.
- dq_out  out  DQ_WIDTH  write data.
- dq_mask  out  DQ_WIDTH/8  byte masks, active-high (byte not written).
- dq_oe  out  1  dq drive enable.
- fifo_data  in  BEATS*(DQ_WIDTH+DQ_WIDTH/8)  entry layout {masks, data}. Beat 0 is the most-significant slice of each field.
- fifo_empty  in  1  FIFO empty.
- fifo_rd  out  1  pops one entry; high for one cycle.

Behaviour:
- Reset values: command=NOP; addr, bank, dq_out, dq_mask, dq_oe, fifo_rd and refresh_ack all 0; state=IDLE; delay=0; refresh pending cleared. Reset mid-operation aborts immediately; the row is not precharged. The controller re-initialises the device after reset.
- Delay counter: while non-zero, command=NOP, dq_oe=0, and the state is held.
- Refresh capture: auto_refresh & en sets a pending flag. The flag clears when AR is issued.
- IDLE:
  - If refresh is pending: issue AR, set delay=T_RFC-1, pulse refresh_ack. Refresh has priority over starting a write.
  - Else if en & !fifo_empty: latch address, go to ACTIVATE.
  - ready = IDLE & delay==0 & !pending.
- ACTIVATE: issue ACT with addr=row, bank=bank; delay=T_RCD-1; go to WRITE.
- WRITE, one cycle per beat b (0..BEATS-1), with SDRAM burst length 1:
  - command=WRITE; addr={zeros, A10=0, column zero-extended}; dq_out=beat b data; dq_mask=beat b mask; dq_oe=1.
  - The word address increments by 1 after each beat and wraps modulo 2^(BANK_BITS+ROW_BITS+COL_BITS).
  - fifo_rd=1 on the cycle of beat BEATS-1.
- After the last beat of an entry:
  - Continue in WRITE with the next entry's beat 0 (no gap) only if all hold: fifo_empty was low before this pop, no refresh is pending, en=1, and the column did not wrap to 0.
  - Otherwise go to WR_RECOVER. Entries are never split; a column wrap mid-entry is prevented because the start address is BEATS-aligned. Behaviour with an unaligned start address is undefined.
- WR_RECOVER: NOP for T_WR cycles, then PRECHARGE.
- PRECHARGE: issue PRE with A10=1 (all banks); delay=T_RP-1. Next state:
  - REFRESH if refresh is pending.
  - ACTIVATE if en & !fifo_empty. The latched incremented address is kept, so a row/bank crossing continues there.
  - IDLE otherwise.
- REFRESH: issue AR, set delay=T_RFC-1, pulse refresh_ack; then ACTIVATE if en & !fifo_empty, else IDLE.
- en falling mid-entry: the entry completes, then WR_RECOVER, PRECHARGE, IDLE.
- Refresh tick arriving in the same cycle as the last beat: the tick counts as pending, and the engine exits the stream at that entry.
- fifo_rd never asserts while fifo_empty=1.

Test Plan:
- Reset: hold rst 3 cycles mid-stream -> next cycle command=111, dq_oe=0, fifo_rd=0, ready=1 once rst drops.
- Single entry {4'b0010, 16'hABCD, 16'h1234} at address 0x000010 -> expected sequence:
  - ACT bank0/row0.
  - 1 NOP.
  - WRITE col 0x10, dq=ABCD, mask=00.
  - WRITE col 0x11, dq=1234, mask=10, fifo_rd=1.
  - 2 NOPs.
  - PRE with A10=1.
  - 1 NOP, then IDLE.
- Row crossing: 2 entries starting at 0x0000FE -> expected sequence:
  - WRITE col FE, then col FF.
  - WR_RECOVER, then PRE.
  - ACT row 1.
  - WRITE col 00, then col 01.
- Refresh during stream: 4 entries queued, auto_refresh pulsed during entry 1 -> expected sequence:
  - Entry 1 completes.
  - PRE, then AR with refresh_ack=1.
  - 7 NOPs.
  - ACT same row; entries 2-3 written at consecutive columns.
- Simultaneous start and refresh in IDLE: en=1, !fifo_empty, pending refresh -> AR is issued first, then ACT after T_RFC.
- FIFO runs dry: 1 entry, then 10 empty cycles, then 1 entry -> expected sequence:
  - PRE, then IDLE; busy=0.
  - On refill: new ACT from the address input.
